// File: rtl/gelato_types.sv
// Shared types and sizing for the gelato instruction buffer.
// Covers the decoded instruction format and the per-warp FIFO entry.
package gelato_types;

   localparam int NUM_WARPS  = 4;
   localparam int IBUF_DEPTH = 4;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } inst_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] thread_mask;
      inst_t       inst;
   } ibuf_entry_t;

endpackage

// File: rtl/gelato_inst_buffer_if.sv
// Decode-to-scheduler bus of the instruction buffer.
// The slave side is the buffer and the master side is the decode/scheduler environment.
interface gelato_inst_buffer_if #(
   parameter int NUM_WARPS = gelato_types::NUM_WARPS,
   parameter int WARP_W    = $clog2(NUM_WARPS)
);
   import gelato_types::inst_t;

   logic                 in_valid;
   logic [31:0]          in_pc;
   logic [WARP_W-1:0]    in_warp_num;
   logic [31:0]          in_thread_mask;
   inst_t                in_inst;

   logic                 flush_valid;
   logic [WARP_W-1:0]    flush_warp;

   logic [NUM_WARPS-1:0] warp_stall;

   logic                 issue_valid;
   logic                 issue_ready;
   logic [31:0]          issue_pc;
   logic [WARP_W-1:0]    issue_warp_num;
   logic [31:0]          issue_thread_mask;
   inst_t                issue_inst;

   logic                 overflow_err;

   modport master (
      output in_valid, in_pc, in_warp_num, in_thread_mask, in_inst,
      output flush_valid, flush_warp, issue_ready,
      input  warp_stall, issue_valid, issue_pc, issue_warp_num,
      input  issue_thread_mask, issue_inst, overflow_err
   );

   modport slave (
      input  in_valid, in_pc, in_warp_num, in_thread_mask, in_inst,
      input  flush_valid, flush_warp, issue_ready,
      output warp_stall, issue_valid, issue_pc, issue_warp_num,
      output issue_thread_mask, issue_inst, overflow_err
   );

endinterface

// File: rtl/gelato_ibuf_fifo.sv
// Single-warp instruction FIFO with a combinational head and a synchronous flush.
// Full/empty protection belongs to the caller, which only pushes or pops when that is legal.
module gelato_ibuf_fifo
   import gelato_types::ibuf_entry_t;
#(
   parameter int  DEPTH = gelato_types::IBUF_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  ibuf_entry_t       push_data,
   output logic [CNT_W-1:0]  count,
   output ibuf_entry_t       head
);

   ibuf_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is never reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer: one FIFO per warp, round-robin selection into a
// single issue register, per-warp fetch stall and a sticky overflow flag.
module gelato_inst_buffer
   import gelato_types::ibuf_entry_t;
#(
   parameter int NUM_WARPS  = gelato_types::NUM_WARPS,
   parameter int IBUF_DEPTH = gelato_types::IBUF_DEPTH,
   parameter int WARP_W     = $clog2(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 rst,
   gelato_inst_buffer_if.slave  bus
);

   localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

   logic [CNT_W-1:0]     count [NUM_WARPS];
   ibuf_entry_t          head  [NUM_WARPS];
   ibuf_entry_t          in_entry;
   logic [NUM_WARPS-1:0] push, pop, flush, full, ovf, eligible, stall;
   logic [WARP_W-1:0]    rr_ptr, sel_warp;
   logic                 sel_found, load, flush_hit;

   assign in_entry = '{pc: bus.in_pc, thread_mask: bus.in_thread_mask, inst: bus.in_inst};
   assign flush_hit = bus.flush_valid && (bus.issue_warp_num == bus.flush_warp);
   assign load = (!bus.issue_valid || bus.issue_ready) && sel_found && !flush_hit;
   assign bus.warp_stall = stall;

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      logic is_target;

      assign flush[w]    = bus.flush_valid && (bus.flush_warp == WARP_W'(w));
      assign pop[w]      = load && (sel_warp == WARP_W'(w));
      assign is_target   = bus.in_valid && (bus.in_warp_num == WARP_W'(w)) && !flush[w];
      assign full[w]     = (count[w] == CNT_W'(IBUF_DEPTH));
      // A full FIFO still accepts a write when its head leaves in the same cycle.
      assign push[w]     = is_target && (!full[w] || pop[w]);
      assign ovf[w]      = is_target && full[w] && !pop[w];
      assign eligible[w] = (count[w] != '0) && !flush[w];
      assign stall[w]    = (count[w] >= CNT_W'(IBUF_DEPTH - 2));

      gelato_ibuf_fifo #(.DEPTH(IBUF_DEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[w]),
         .pop       (pop[w]),
         .flush     (flush[w]),
         .push_data (in_entry),
         .count     (count[w]),
         .head      (head[w])
      );
   end

   always_comb begin : p_rr_search
      int idx;
      sel_found = 1'b0;
      sel_warp  = '0;
      idx       = 0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_WARPS;
         if (!sel_found && eligible[idx[WARP_W-1:0]]) begin
            sel_found = 1'b1;
            sel_warp  = idx[WARP_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.issue_valid       <= 1'b0;
         bus.issue_pc          <= '0;
         bus.issue_warp_num    <= '0;
         bus.issue_thread_mask <= '0;
         bus.issue_inst        <= '0;
         bus.overflow_err      <= 1'b0;
         rr_ptr                <= '0;
      end else begin
         if (|ovf) bus.overflow_err <= 1'b1;
         if (flush_hit) begin
            bus.issue_valid <= 1'b0;
         end else if (load) begin
            bus.issue_valid       <= 1'b1;
            bus.issue_pc          <= head[sel_warp].pc;
            bus.issue_warp_num    <= sel_warp;
            bus.issue_thread_mask <= head[sel_warp].thread_mask;
            bus.issue_inst        <= head[sel_warp].inst;
            rr_ptr <= (sel_warp == WARP_W'(NUM_WARPS - 1)) ? '0 : sel_warp + 1'b1;
         end else if (bus.issue_ready) begin
            bus.issue_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gelato_inst_buffer.sv
// Directed bench for gelato_inst_buffer: latency, round-robin order, stall/overflow,
// flush of a held warp, full push+pop and asynchronous reset mid-operation.
module tb_gelato_inst_buffer;
   import gelato_types::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   int          rr_exp_w  [6] = '{0, 2, 3, 0, 2, 3};
   logic [31:0] rr_exp_pc [6] = '{32'h200, 32'h220, 32'h230, 32'h204, 32'h224, 32'h234};
   logic [31:0] so_exp_pc [4] = '{32'h300, 32'h304, 32'h308, 32'h30C};
   logic [31:0] fp_exp_pc [4] = '{32'h508, 32'h50C, 32'h510, 32'h514};

   gelato_inst_buffer_if bus ();

   gelato_inst_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic inst_t mk_inst(input logic [31:0] pc);
      mk_inst = '{opcode: pc[6:0], rd: pc[11:7], rs1: pc[16:12], rs2: pc[21:17], imm: ~pc};
   endfunction

   task automatic drive_write(input int w, input logic [31:0] pc);
      bus.in_valid       = 1'b1;
      bus.in_warp_num    = 2'(w);
      bus.in_pc          = pc;
      bus.in_thread_mask = pc ^ 32'hFFFF_0000;
      bus.in_inst        = mk_inst(pc);
   endtask

   task automatic write_tick(input int w, input logic [31:0] pc);
      drive_write(w, pc);
      tick();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      rst                = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_pc          = '0;
      bus.in_warp_num    = '0;
      bus.in_thread_mask = '0;
      bus.in_inst        = '0;
      bus.flush_valid    = 1'b0;
      bus.flush_warp     = '0;
      bus.issue_ready    = 1'b0;
      #12;
      check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      check("rst_overflow", 64'(bus.overflow_err), 64'd0);
      check("rst_warp_stall", 64'(bus.warp_stall), 64'd0);
      check("rst_issue_pc", 64'(bus.issue_pc), 64'd0);
      check("rst_issue_warp", 64'(bus.issue_warp_num), 64'd0);
      rst = 1'b0;
      tick();

      // Basic latency: no bypass, one-cycle output, then empty.
      bus.issue_ready = 1'b1;
      write_tick(1, 32'h100);
      idle();
      check("lat_no_bypass", 64'(bus.issue_valid), 64'd0);
      tick();
      check("lat_valid", 64'(bus.issue_valid), 64'd1);
      check("lat_pc", 64'(bus.issue_pc), 64'h100);
      check("lat_warp", 64'(bus.issue_warp_num), 64'd1);
      check("lat_mask", 64'(bus.issue_thread_mask), 64'hFFFF_0100);
      check("lat_inst", 64'(bus.issue_inst), 64'(mk_inst(32'h100)));
      tick();
      check("lat_drop", 64'(bus.issue_valid), 64'd0);

      // Round-robin over warps 0, 2, 3.
      bus.issue_ready = 1'b0;
      write_tick(0, 32'h200);
      write_tick(0, 32'h204);
      write_tick(2, 32'h220);
      write_tick(2, 32'h224);
      write_tick(3, 32'h230);
      write_tick(3, 32'h234);
      idle();
      tick();
      check("rr_hold_pc", 64'(bus.issue_pc), 64'h200);
      bus.issue_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("rr_valid", 64'(bus.issue_valid), 64'd1);
         check("rr_warp", 64'(bus.issue_warp_num), 64'(rr_exp_w[k]));
         check("rr_pc", 64'(bus.issue_pc), 64'(rr_exp_pc[k]));
         tick();
      end
      check("rr_empty", 64'(bus.issue_valid), 64'd0);

      // Stall and overflow with the output register occupied.
      bus.issue_ready = 1'b0;
      write_tick(1, 32'h3F0);
      idle();
      tick();
      write_tick(0, 32'h300);
      check("so_stall_1", 64'(bus.warp_stall), 64'b0000);
      write_tick(0, 32'h304);
      check("so_stall_2", 64'(bus.warp_stall), 64'b0001);
      write_tick(0, 32'h308);
      write_tick(0, 32'h30C);
      check("so_no_ovf_4", 64'(bus.overflow_err), 64'd0);
      write_tick(0, 32'h310);
      idle();
      check("so_ovf_5", 64'(bus.overflow_err), 64'd1);
      bus.issue_ready = 1'b1;
      check("so_held_pc", 64'(bus.issue_pc), 64'h3F0);
      check("so_held_warp", 64'(bus.issue_warp_num), 64'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("so_drain_valid", 64'(bus.issue_valid), 64'd1);
         check("so_drain_pc", 64'(bus.issue_pc), 64'(so_exp_pc[k]));
         tick();
      end
      check("so_drained", 64'(bus.issue_valid), 64'd0);
      check("so_ovf_sticky", 64'(bus.overflow_err), 64'd1);
      check("so_stall_clear", 64'(bus.warp_stall), 64'b0000);

      rst = 1'b1;
      #1;
      check("rst_clears_ovf", 64'(bus.overflow_err), 64'd0);
      rst = 1'b0;
      tick();

      // Flush warp 2 while it is held, together with a write to warp 2.
      bus.issue_ready = 1'b0;
      write_tick(2, 32'h400);
      write_tick(2, 32'h404);
      write_tick(2, 32'h408);
      idle();
      check("fl_held_valid", 64'(bus.issue_valid), 64'd1);
      check("fl_held_pc", 64'(bus.issue_pc), 64'h400);
      check("fl_stall_pre", 64'(bus.warp_stall), 64'b0100);
      drive_write(2, 32'h40C);
      bus.flush_valid = 1'b1;
      bus.flush_warp  = 2'd2;
      tick();
      idle();
      bus.flush_valid = 1'b0;
      check("fl_invalid", 64'(bus.issue_valid), 64'd0);
      check("fl_stall_post", 64'(bus.warp_stall), 64'b0000);
      check("fl_no_ovf", 64'(bus.overflow_err), 64'd0);
      bus.issue_ready = 1'b1;
      tick();
      tick();
      check("fl_fifo_empty", 64'(bus.issue_valid), 64'd0);

      // Full FIFO: simultaneous push and pop.
      bus.issue_ready = 1'b0;
      write_tick(1, 32'h500);
      write_tick(1, 32'h504);
      write_tick(1, 32'h508);
      write_tick(1, 32'h50C);
      write_tick(1, 32'h510);
      idle();
      check("fp_held_pc", 64'(bus.issue_pc), 64'h500);
      check("fp_stall_full", 64'(bus.warp_stall), 64'b0010);
      drive_write(1, 32'h514);
      bus.issue_ready = 1'b1;
      tick();
      idle();
      check("fp_pop_pc", 64'(bus.issue_pc), 64'h504);
      check("fp_still_full", 64'(bus.warp_stall), 64'b0010);
      check("fp_no_ovf", 64'(bus.overflow_err), 64'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("fp_order_valid", 64'(bus.issue_valid), 64'd1);
         check("fp_order_pc", 64'(bus.issue_pc), 64'(fp_exp_pc[k]));
      end
      tick();
      check("fp_drained", 64'(bus.issue_valid), 64'd0);

      // Asynchronous reset with three warps populated.
      bus.issue_ready = 1'b0;
      write_tick(0, 32'h600);
      write_tick(1, 32'h610);
      write_tick(1, 32'h614);
      write_tick(3, 32'h630);
      idle();
      check("ar_pre_valid", 64'(bus.issue_valid), 64'd1);
      check("ar_pre_pc", 64'(bus.issue_pc), 64'h600);
      check("ar_pre_stall", 64'(bus.warp_stall), 64'b0010);
      #2;
      rst = 1'b1;
      #1;
      check("ar_valid", 64'(bus.issue_valid), 64'd0);
      check("ar_pc", 64'(bus.issue_pc), 64'd0);
      check("ar_warp", 64'(bus.issue_warp_num), 64'd0);
      check("ar_mask", 64'(bus.issue_thread_mask), 64'd0);
      check("ar_stall", 64'(bus.warp_stall), 64'd0);
      check("ar_ovf", 64'(bus.overflow_err), 64'd0);
      #1;
      rst = 1'b0;
      bus.issue_ready = 1'b1;
      write_tick(3, 32'h700);
      idle();
      check("ar_post_latency", 64'(bus.issue_valid), 64'd0);
      tick();
      check("ar_post_valid", 64'(bus.issue_valid), 64'd1);
      check("ar_post_pc", 64'(bus.issue_pc), 64'h700);
      check("ar_post_warp", 64'(bus.issue_warp_num), 64'd3);
      tick();
      check("ar_discarded", 64'(bus.issue_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gelato_inst_buffer.md
GELATO_INST_BUFFER -- requirements
Module: gelato_inst_buffer

Interface
REQ-001 Parameter NUM_WARPS, 4, number of warps; each warp has one FIFO.
REQ-002 Parameter IBUF_DEPTH, 4, entries per warp FIFO; power of two, at least 4.
REQ-003 Parameter WARP_W, $clog2(NUM_WARPS), width of the warp number.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  decoded instruction present this cycle; no ready is returned to the decode stage.
REQ-007 in_pc  in  32  PC of the decoded instruction.
REQ-008 in_warp_num  in  WARP_W  target warp FIFO.
REQ-009 in_thread_mask  in  32  active-thread mask.
REQ-010 in_inst  in  inst_t  decoded instruction.
REQ-011 flush_valid  in  1  discard all buffered instructions of one warp.
REQ-012 flush_warp  in  WARP_W  warp to flush.
REQ-013 warp_stall  out  NUM_WARPS  per-warp back-pressure to instruction fetch.
REQ-014 issue_valid  out  1  output register holds an instruction.
REQ-015 issue_ready  in  1  scheduler accepts the output this cycle.
REQ-016 issue_pc / issue_warp_num / issue_thread_mask / issue_inst  out  32 / WARP_W / 32 / inst_t  output register fields.
REQ-017 overflow_err  out  1  sticky flag: a write arrived for a full FIFO.

Function
REQ-018 A write (in_valid=1) SHALL push {pc, thread_mask, inst} into FIFO[in_warp_num] at the clock edge.
REQ-019 A write to a full FIFO SHALL be dropped and SHALL set overflow_err, which stays high until reset.
REQ-020 warp_stall[w] SHALL equal (count[w] >= IBUF_DEPTH-2) as a combinational function of registered counts, giving two cycles of slack for the fetch and decode stages.
REQ-021 The output register SHALL load when (!issue_valid || issue_ready) and at least one FIFO is non-empty; the load pops the head of the selected warp in the same edge.
REQ-022 Selection SHALL be round-robin: search warps rr_ptr, rr_ptr+1, ... mod NUM_WARPS, and take the first non-empty one.
REQ-023 After a load from warp w, rr_ptr SHALL become (w+1) mod NUM_WARPS; without a load, rr_ptr is unchanged.
REQ-024 issue_valid && !issue_ready SHALL hold every output field stable.
REQ-025 If issue_ready=1 and no FIFO is non-empty, issue_valid SHALL go low at the next edge.
REQ-026 Latency: an entry written at edge t SHALL be eligible for selection in cycle t+1 and appear with issue_valid high after edge t+1 at the earliest; there is no write-to-output bypass.
REQ-027 A simultaneous push and pop on the same FIFO SHALL both occur, leaving the count unchanged; this is legal even when the FIFO is full.
REQ-028 flush_valid SHALL zero the count and pointers of FIFO[flush_warp] at the edge.
REQ-029 Flush SHALL suppress any same-cycle pop from the flushed warp.
REQ-030 Flush SHALL drop any same-cycle write to the flushed warp without setting overflow_err.
REQ-031 If issue_warp_num == flush_warp, the output register SHALL be invalidated at the edge whether or not issue_ready is high, and SHALL NOT reload that cycle.
REQ-032 Per-FIFO pointers SHALL wrap modulo IBUF_DEPTH, and count SHALL be $clog2(IBUF_DEPTH)+1 bits wide.

Reset
REQ-033 While rst is high, all counts, pointers and rr_ptr SHALL be 0, and issue_valid, overflow_err and warp_stall SHALL be 0.
REQ-034 Output data fields SHALL reset to 0.
REQ-035 FIFO storage SHALL NOT require reset.
REQ-036 Reset asserted mid-operation SHALL discard all buffered and in-flight entries immediately (asynchronously).

Structure
REQ-037 NUM_WARPS, IBUF_DEPTH and the ibuf_entry_t struct {pc, thread_mask, inst} SHALL live in gelato_types, beside inst_t.
REQ-038 The per-warp storage SHALL be one sub-module, gelato_ibuf_fifo, instantiated NUM_WARPS times; it provides push, pop, flush, count and head.
REQ-039 Arbitration and the output register SHALL be implemented in gelato_inst_buffer.

Verification
REQ-040 Basic latency: write warp 1, pc=0x100, with issue_ready=1 -> issue_valid high exactly after the next edge with pc=0x100 and warp_num=1, then low after the following edge.
REQ-041 Round-robin: preload warps 0, 2 and 3 with two entries each, hold issue_ready=1 -> issue order is warps 0, 2, 3, 0, 2, 3.
REQ-042 Stall and overflow: write five entries to warp 0 with issue_ready=0 -> warp_stall[0] rises after the 2nd write, the 5th write is dropped, overflow_err=1, and draining yields four entries in order.
REQ-043 Flush while holding: warp 2 held in the output register with two more queued, pulse flush_warp=2 together with a write to warp 2 -> issue_valid=0, FIFO[2] empty, overflow_err=0.
REQ-044 Full push and pop: warp 1 full (4 entries), same-cycle write and issue -> count stays 4 and FIFO order is preserved.
REQ-045 Reset mid-operation: assert rst asynchronously between edges with three warps populated -> all outputs are 0 immediately, and the first post-reset write issues normally.
